// File: rtl/frame_writer.sv
// frame_writer: packs an RGB888 pixel stream to RGB332, buffers it in a
// small show-ahead FIFO and writes exactly one frame to sequential addresses.
// Ports: p_clock/rst (async, active-high); start arms a capture; vsync,
// pixel_data, pixel_valid from the sensor path; mem_ready/mem_we/mem_addr/
// mem_data to the frame buffer; busy, done pulse, sticky overflow/short_frame.
module frame_writer #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              p_clock,
    input  logic              rst,
    input  logic              start,
    input  logic              vsync,
    input  logic [23:0]       pixel_data,
    input  logic              pixel_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              short_frame
);
    localparam int TOTAL = H_RES * V_RES;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              seen_hi_q, seen_hi_d;
    logic [CNT_W-1:0]  push_cnt_q, push_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [7:0]        fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              ovf_q, ovf_d;
    logic              short_q, short_d;

    logic [7:0] px332;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       unused_bits;

    assign px332       = {pixel_data[7:5], pixel_data[15:13], pixel_data[23:22]};
    assign unused_bits = ^{pixel_data[21:16], pixel_data[12:8], pixel_data[4:0]};

    assign fifo_empty  = (occ_q == '0);
    assign fifo_full   = (occ_q == DEPTH_C);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign mem_we      = busy && !fifo_empty;
    assign mem_addr    = addr_q;
    assign mem_data    = fifo_q[rd_ptr_q];
    assign overflow    = ovf_q;
    assign short_frame = short_q;

    // Fullness is judged on the start-of-cycle count, so a push into a
    // full FIFO is dropped even when a pop frees a slot in the same cycle.
    assign push_req = (state_q == S_WRITE) && pixel_valid
                      && (push_cnt_q < TOTAL_C);
    assign push     = push_req && !fifo_full;
    assign pop      = mem_we && mem_ready;

    always_comb begin
        state_d    = state_q;
        seen_hi_d  = seen_hi_q;
        push_cnt_d = push_cnt_q;
        addr_d     = addr_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        ovf_d      = ovf_q;
        short_d    = short_q;

        if (push) begin
            fifo_d[wr_ptr_q] = px332;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            push_cnt_d       = push_cnt_q + CNT_W'(1);
        end
        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ARM;
                    seen_hi_d  = 1'b0;
                    push_cnt_d = '0;
                    addr_d     = '0;
                    ovf_d      = 1'b0;
                    short_d    = 1'b0;
                end
            end
            S_ARM: begin
                // Only a high-then-low vsync marks a real frame start.
                if (vsync) begin
                    seen_hi_d = 1'b1;
                end else if (seen_hi_q) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (push_cnt_d == TOTAL_C) begin
                    state_d = S_DRAIN;
                end else if (vsync) begin
                    short_d = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            seen_hi_q  <= 1'b0;
            push_cnt_q <= '0;
            addr_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            ovf_q      <= 1'b0;
            short_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            seen_hi_q  <= seen_hi_d;
            push_cnt_q <= push_cnt_d;
            addr_q     <= addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            ovf_q      <= ovf_d;
            short_q    <= short_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed frames with a write scoreboard for frame_writer.
// Covers reset, packing, normal/short frames, backpressure, ignore rules.
module tb_frame_writer;
    localparam int TOTAL = 19200;

    logic        p_clock;
    logic        rst;
    logic        start;
    logic        vsync;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        short_frame;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int occ = 0;
    int pcnt = 0;
    logic [14:0] addr_exp = '0;
    logic [22:0] exp_q [$];

    frame_writer dut (
        .p_clock    (p_clock),
        .rst        (rst),
        .start      (start),
        .vsync      (vsync),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .short_frame(short_frame)
    );

    initial p_clock = 1'b0;
    always #5 p_clock = ~p_clock;

    function automatic logic [7:0] pack(input logic [23:0] d);
        return {d[7:5], d[15:13], d[23:22]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clock);
        #1;
    endtask

    // Drives one cycle and predicts, from the FIFO occupancy at the start
    // of the cycle, whether the pixel is accepted; accepted pixels are
    // queued with the address they must be written to.
    task automatic step(input logic v, input logic [23:0] d,
                        input logic rdy);
        logic acc;
        logic pp;
        pixel_valid = v;
        pixel_data  = d;
        mem_ready   = rdy;
        acc = v && (occ < 4) && (pcnt < TOTAL);
        pp  = (occ > 0) && rdy;
        if (acc) begin
            exp_q.push_back({addr_exp, pack(d)});
            addr_exp++;
            pcnt++;
        end
        occ = occ + int'(acc) - int'(pp);
        tick();
    endtask

    task automatic arm();
        occ      = 0;
        pcnt     = 0;
        addr_exp = '0;
        done_cnt = 0;
        check("idle_before_start", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        vsync       = 1'b1;
        pixel_valid = 1'b1;
        pixel_data  = 24'hFFFFFF;
        repeat (3) tick();
        check("no_write_in_arm", mem_we, 0);
        vsync = 1'b0;
        tick();
        check("no_write_at_vsync_fall", mem_we, 0);
        pixel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick();
        end
        check("frame_end_idle", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        check("done_once", done_cnt, 1);
    endtask

    always @(negedge p_clock) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (mem_we && mem_ready) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_write observed=%0h expected=none",
                           mem_addr);
                end
                if (exp_q.size() > 0) begin
                    logic [22:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e[22:8]);
                    check("wr_data", mem_data, e[7:0]);
                end
            end
        end
    end

    initial begin
        logic [14:0] held;
        rst         = 1'b1;
        start       = 1'b0;
        vsync       = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        mem_ready   = 1'b1;
        tick();
        tick();
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_short", short_frame, 0);
        rst = 1'b0;
        tick();

        // Normal frame with packing checks, ignored start and late pixels.
        arm();
        step(1'b1, 24'h00FF00, 1'b1);
        check("latency_we", mem_we, 1);
        check("pack_green", mem_data, 8'h1C);
        step(1'b1, 24'hC000E0, 1'b1);
        check("pack_blue_red", mem_data, 8'hE3);
        while (pcnt < TOTAL) begin
            start = (pcnt == 1000);
            step(1'b1, 24'($urandom), 1'b1);
        end
        start = 1'b0;
        repeat (5) step(1'b1, 24'($urandom), 1'b1);
        pixel_valid = 1'b0;
        wait_idle();
        check("normal_addr", mem_addr, TOTAL);
        check("normal_ovf", overflow, 0);
        check("normal_short", short_frame, 0);

        // Short frame: vsync rises after 500 pixels.
        arm();
        repeat (500) step(1'b1, 24'($urandom), 1'b1);
        pixel_valid = 1'b0;
        vsync       = 1'b1;
        tick();
        wait_idle();
        vsync = 1'b0;
        check("short_flag", short_frame, 1);
        check("short_addr", mem_addr, 500);
        check("short_ovf", overflow, 0);

        // Reset in the middle of a frame.
        arm();
        repeat (100) step(1'b1, 24'($urandom), 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_we", mem_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", mem_addr, 0);
        exp_q.delete();
        pixel_valid = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("no_write_after_rst", mem_we, 0);
        pixel_valid = 1'b0;

        // Full frame after reset, with a 10-cycle stall on the write side.
        arm();
        held = '0;
        for (int i = 0; pcnt < TOTAL; i++) begin
            if (i == 2000) held = mem_addr;
            step(1'b1, 24'($urandom), !(i >= 2000 && i < 2010));
            if (i >= 2000 && i < 2010) begin
                check("stall_addr_hold", mem_addr, held);
                check("stall_we", mem_we, 1);
            end
            if (i == 2010) check("stall_ovf", overflow, 1);
        end
        pixel_valid = 1'b0;
        wait_idle();
        check("bp_addr", mem_addr, TOTAL);
        check("bp_ovf", overflow, 1);
        check("bp_short", short_frame, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
